clk_gate_ctrl: RTL and testbench

CLK_GATE_CTRL -- requirements
Module: clk_gate_ctrl

---
 rtl/clk_gate_ctrl_pkg.sv | 23 ++
 rtl/clk_gate_ctrl_channel.sv | 100 ++++++++++
 rtl/clk_gate_ctrl_icg.sv | 20 ++
 rtl/clk_gate_ctrl.sv | 62 ++++++
 tb/tb_clk_gate_ctrl.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/clk_gate_ctrl_pkg.sv
// Shared definitions for the per-channel clock-gate controller:
// channel state encoding, parameter limits and counter sizing.
package clk_gate_ctrl_pkg;

  typedef enum logic [1:0] {
    CH_OFF   = 2'd0,
    CH_WAKE  = 2'd1,
    CH_ON    = 2'd2,
    CH_DRAIN = 2'd3
  } ch_state_e;

  localparam int unsigned NUM_CH_MIN   = 32'd1;
  localparam int unsigned NUM_CH_MAX   = 32'd16;
  localparam int unsigned WAKE_CYC_MIN = 32'd1;
  localparam int unsigned WAKE_CYC_MAX = 32'd15;
  localparam int unsigned WAKE_CNT_W   = 32'd4;

  // One counter serves both wake and idle timing, so it must fit the wider of the two.
  function automatic int unsigned cnt_width(input int unsigned idle_w);
    return (idle_w > WAKE_CNT_W) ? idle_w : WAKE_CNT_W;
  endfunction

endpackage

// File: rtl/clk_gate_ctrl_channel.sv
// One gated-clock channel: OFF -> WAKE -> ON <-> DRAIN -> OFF sequencing with
// a shared saturating counter for wake latency and idle hysteresis.
module cgc_channel
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              act,
  input  logic [IDLE_W-1:0] idle_thr,
  output logic              ch_en,
  output logic              ch_rdy,
  output logic              off_nxt
);

  localparam int unsigned CNT_W = cnt_width(IDLE_W);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYC - 1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             en_q, en_d;
  logic             rdy_q, rdy_d;

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CH_OFF: begin
        if (act) begin
          state_d = CH_WAKE;
          cnt_d   = WAKE_LOAD;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      CH_WAKE: begin
        // Wake always runs to completion, regardless of act.
        if (cnt_q == CNT_ZERO) begin
          state_d = CH_ON;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      CH_ON: begin
        if (act) begin
          state_d = CH_ON;
        end else if (idle_thr == {IDLE_W{1'b0}}) begin
          state_d = CH_OFF;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = CH_DRAIN;
          cnt_d   = CNT_W'(idle_thr);
        end
      end
      CH_DRAIN: begin
        // Leaving when the count would reach zero gives N+1 idle edges in total.
        if (act) begin
          state_d = CH_ON;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q <= CNT_ONE) begin
          state_d = CH_OFF;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = CH_OFF;
        cnt_d   = CNT_ZERO;
      end
    endcase
    en_d    = (state_d != CH_OFF);
    rdy_d   = (state_d == CH_ON) || (state_d == CH_DRAIN);
    off_nxt = (state_d == CH_OFF);
  end

  // Channel state and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= CH_OFF;
      cnt_q   <= CNT_ZERO;
      en_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      rdy_q   <= rdy_d;
    end
  end

  assign ch_en  = en_q;
  assign ch_rdy = rdy_q;

endmodule

// File: rtl/clk_gate_ctrl_icg.sv
// Latch-based integrated clock gate: the enable is captured while the clock
// is low, so an enable change can never truncate or create a high pulse.
module cgc_clk_gate (
  input  logic CLK,
  input  logic en,
  output logic gclk
);

  logic en_l;

  // Transparent-low enable latch.
  always_latch begin
    if (!CLK) begin
      en_l <= en;
    end
  end

  assign gclk = CLK & en_l;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gate controller: NUM_CH independent channel FSMs, each
// driving its own ICG; test_en opens every gate without touching the FSMs.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned IDLE_W   = 8,
  parameter int unsigned WAKE_CYC = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              test_en,
  input  logic [NUM_CH-1:0] REQ,
  input  logic [NUM_CH-1:0] FORCE_ON,
  input  logic [IDLE_W-1:0] IDLE_THR,
  output logic [NUM_CH-1:0] GATED_CLK,
  output logic [NUM_CH-1:0] CH_EN,
  output logic [NUM_CH-1:0] CH_RDY,
  output logic              ALL_OFF
);

  logic [NUM_CH-1:0] off_nxt_s;
  logic              all_off_q, all_off_d;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cgc_channel #(
      .IDLE_W   (IDLE_W),
      .WAKE_CYC (WAKE_CYC)
    ) u_ch (
      .CLK      (CLK),
      .RST      (RST),
      .act      (REQ[i] | FORCE_ON[i]),
      .idle_thr (IDLE_THR),
      .ch_en    (CH_EN[i]),
      .ch_rdy   (CH_RDY[i]),
      .off_nxt  (off_nxt_s[i])
    );

    cgc_clk_gate u_icg (
      .CLK  (CLK),
      .en   (CH_EN[i] | test_en),
      .gclk (GATED_CLK[i])
    );
  end

  // All-off flag tracks the channel next-states so it lines up with the state registers.
  always_comb begin
    all_off_d = &off_nxt_s;
  end

  // All-off register, set while in reset.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      all_off_q <= 1'b1;
    end else begin
      all_off_q <= all_off_d;
    end
  end

  assign ALL_OFF = all_off_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: a per-cycle compare against a
// behavioural channel model, plus directed scenarios with literal expectations.
module tb_clk_gate_ctrl;

  localparam int NUM_CH   = 4;
  localparam int IDLE_W   = 8;
  localparam int WAKE_CYC = 2;

  logic              CLK      = 1'b0;
  logic              RST      = 1'b1;
  logic              test_en  = 1'b0;
  logic [NUM_CH-1:0] REQ      = 4'b0000;
  logic [NUM_CH-1:0] FORCE_ON = 4'b0000;
  logic [IDLE_W-1:0] IDLE_THR = 8'd3;
  logic [NUM_CH-1:0] GATED_CLK;
  logic [NUM_CH-1:0] CH_EN;
  logic [NUM_CH-1:0] CH_RDY;
  logic              ALL_OFF;

  int n_tests = 0;
  int n_fail  = 0;
  int ecount  = 0;
  int base    = 0;

  // Model: a channel is "enabled" from its wake edge, "ready" WAKE_CYC edges
  // later, and drops both after IDLE_THR+1 consecutive idle edges while ready.
  logic [NUM_CH-1:0] en_m  = 4'b0000;
  logic [NUM_CH-1:0] rdy_m = 4'b0000;
  int wake_age [NUM_CH];
  int idle_run [NUM_CH];
  int thr_m    [NUM_CH];

  clk_gate_ctrl #(
    .NUM_CH   (NUM_CH),
    .IDLE_W   (IDLE_W),
    .WAKE_CYC (WAKE_CYC)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .test_en   (test_en),
    .REQ       (REQ),
    .FORCE_ON  (FORCE_ON),
    .IDLE_THR  (IDLE_THR),
    .GATED_CLK (GATED_CLK),
    .CH_EN     (CH_EN),
    .CH_RDY    (CH_RDY),
    .ALL_OFF   (ALL_OFF)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t edge=%0d)", name, got, exp, $time, ecount);
    end
  endtask

  task automatic wait_edge(input int k);
    while (ecount < k) @(negedge CLK);
  endtask

  initial begin
    forever begin
      @(negedge RST);
      en_m  = 4'b0000;
      rdy_m = 4'b0000;
    end
  end

  initial begin
    forever begin
      logic [NUM_CH-1:0] g_exp;
      logic [NUM_CH-1:0] act;
      @(posedge CLK);
      g_exp = en_m | {NUM_CH{test_en}};
      if (RST) begin
        act = REQ | FORCE_ON;
        for (int i = 0; i < NUM_CH; i++) begin
          if (!en_m[i]) begin
            if (act[i]) begin
              en_m[i]     = 1'b1;
              wake_age[i] = 1;
            end
          end else if (!rdy_m[i]) begin
            wake_age[i]++;
            if (wake_age[i] > WAKE_CYC) begin
              rdy_m[i]    = 1'b1;
              idle_run[i] = 0;
            end
          end else if (act[i]) begin
            idle_run[i] = 0;
          end else begin
            if (idle_run[i] == 0) thr_m[i] = int'(IDLE_THR);
            idle_run[i]++;
            if (idle_run[i] > thr_m[i]) begin
              en_m[i]  = 1'b0;
              rdy_m[i] = 1'b0;
            end
          end
        end
        ecount++;
      end
      #1;
      chk("gated_clk_high_phase", 32'(GATED_CLK), 32'(g_exp));
      chk("ch_en_model", 32'(CH_EN), 32'(en_m));
      chk("ch_rdy_model", 32'(CH_RDY), 32'(rdy_m));
      chk("all_off_model", 32'(ALL_OFF), 32'(en_m == 4'b0000));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", ecount);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("reset_ch_en", 32'(CH_EN), 32'd0);
    chk("reset_ch_rdy", 32'(CH_RDY), 32'd0);
    chk("reset_all_off", 32'(ALL_OFF), 32'd1);
    RST = 1'b1;

    // Channel 0 wake: request sampled at edge 10.
    wait_edge(9);
    REQ[0] = 1'b1;
    @(posedge CLK); #1;
    chk("gclk0_edge10_low", 32'(GATED_CLK[0]), 32'd0);
    @(negedge CLK);
    chk("ch_en0_after10", 32'(CH_EN[0]), 32'd1);
    chk("ch_rdy0_after10", 32'(CH_RDY[0]), 32'd0);
    chk("all_off_after10", 32'(ALL_OFF), 32'd0);
    @(posedge CLK); #1;
    chk("gclk0_edge11_pulse", 32'(GATED_CLK[0]), 32'd1);
    @(negedge CLK);
    chk("ch_rdy0_after11", 32'(CH_RDY[0]), 32'd0);
    @(negedge CLK);
    chk("ch_rdy0_after12", 32'(CH_RDY[0]), 32'd1);

    // Channel 1 drain with IDLE_THR=3: idle from edge 21, gate drops after edge 24.
    REQ[1] = 1'b1;
    wait_edge(20);
    REQ[1] = 1'b0;
    wait_edge(23);
    chk("ch_en1_after23", 32'(CH_EN[1]), 32'd1);
    wait_edge(24);
    chk("ch_en1_after24", 32'(CH_EN[1]), 32'd0);
    chk("ch_rdy1_after24", 32'(CH_RDY[1]), 32'd0);

    // Channel 2 re-request during drain keeps the channel ready throughout.
    wait_edge(25);
    REQ[2] = 1'b1;
    for (int k = 29; k <= 40; k++) begin
      wait_edge(k);
      if (k == 30) REQ[2] = 1'b0;
      if (k == 32) REQ[2] = 1'b1;
      chk("ch2_rdy_unbroken", 32'(CH_RDY[2]), 32'd1);
    end

    // Channel 3 single-cycle pulse with IDLE_THR=0: off one edge after ON.
    wait_edge(45);
    IDLE_THR = 8'd0;
    wait_edge(50);
    REQ[3] = 1'b1;
    wait_edge(51);
    REQ[3] = 1'b0;
    chk("ch_en3_pulse_wake", 32'(CH_EN[3]), 32'd1);
    wait_edge(53);
    chk("ch_rdy3_pulse_on", 32'(CH_RDY[3]), 32'd1);
    wait_edge(54);
    chk("ch_en3_thr0_off", 32'(CH_EN[3]), 32'd0);

    // Pulse with IDLE_THR=2; threshold change during drain must not matter.
    wait_edge(58);
    IDLE_THR = 8'd2;
    wait_edge(60);
    REQ[3] = 1'b1;
    wait_edge(61);
    REQ[3] = 1'b0;
    wait_edge(64);
    IDLE_THR = 8'd9;
    chk("ch_rdy3_in_drain", 32'(CH_RDY[3]), 32'd1);
    wait_edge(65);
    chk("ch_en3_drain_hold", 32'(CH_EN[3]), 32'd1);
    wait_edge(66);
    chk("ch_en3_thr_sampled", 32'(CH_EN[3]), 32'd0);

    // Everything off, then test_en opens all gates without waking anything.
    wait_edge(70);
    IDLE_THR = 8'd1;
    REQ = 4'b0000;
    wait_edge(73);
    chk("all_off_idle", 32'(ALL_OFF), 32'd1);
    test_en = 1'b1;
    @(posedge CLK); #1;
    chk("test_en_gclk_all", 32'(GATED_CLK), 32'hF);
    @(negedge CLK);
    chk("test_en_ch_en", 32'(CH_EN), 32'd0);
    chk("test_en_all_off", 32'(ALL_OFF), 32'd1);
    repeat (2) @(negedge CLK);
    test_en = 1'b0;

    // Reset asserted mid-wake clears the registered outputs at once.
    wait_edge(80);
    FORCE_ON = 4'b0101;
    @(posedge CLK);
    @(posedge CLK); #2;
    chk("mid_wake_en", 32'(CH_EN), 32'h5);
    RST = 1'b0;
    #1;
    chk("mid_wake_rst_en", 32'(CH_EN), 32'd0);
    chk("mid_wake_rst_rdy", 32'(CH_RDY), 32'd0);
    chk("mid_wake_rst_all_off", 32'(ALL_OFF), 32'd1);
    @(negedge CLK);
    FORCE_ON = 4'b0000;
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    // Maximum threshold: 256 idle edges before the gate drops.
    IDLE_THR = 8'hFF;
    FORCE_ON[1] = 1'b1;
    base = ecount;
    wait_edge(base + 4);
    FORCE_ON[1] = 1'b0;
    wait_edge(base + 259);
    chk("ch_en1_max_thr_hold", 32'(CH_EN[1]), 32'd1);
    wait_edge(base + 260);
    chk("ch_en1_max_thr_off", 32'(CH_EN[1]), 32'd0);

    // Random traffic, all outputs checked every edge against the model.
    IDLE_THR = 8'd2;
    repeat (10000) begin
      @(negedge CLK);
      for (int i = 0; i < NUM_CH; i++) begin
        if ($urandom_range(7, 0) == 0) REQ[i] = ~REQ[i];
        if ($urandom_range(31, 0) == 0) FORCE_ON[i] = ~FORCE_ON[i];
      end
      if ($urandom_range(49, 0) == 0) IDLE_THR = 8'($urandom_range(6, 0));
      if ($urandom_range(999, 0) == 0) IDLE_THR = 8'hFF;
      if ($urandom_range(63, 0) == 0) test_en = ~test_en;
      if ($urandom_range(1999, 0) == 0) begin
        RST = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
      end
    end

    @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
